control_pipe: RTL and testbench

CONTROL_PIPE -- requirements
Module: control_pipe

---
 rtl/control_pipe.sv | 128 ++++++++++++
 tb/tb_control_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// control_pipe: ID-stage decode feeding EX/MEM/WB control registers,
// with a load-use stall FSM and taken-branch flush.
module control_pipe #(
    parameter int ALUOP_W      = 2,
    parameter int REG_AW       = 5,
    parameter int BRANCH_EN    = 1,
    parameter int STALL_CYCLES = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [6:0]         op_i,
    input  logic [REG_AW-1:0]  rs1_i,
    input  logic [REG_AW-1:0]  rs2_i,
    input  logic [REG_AW-1:0]  rd_i,
    input  logic               branch_taken_i,
    output logic               ex_valid_o,
    output logic [ALUOP_W-1:0] ex_aluop_o,
    output logic               ex_alusrc_o,
    output logic               ex_branch_o,
    output logic [REG_AW-1:0]  ex_rd_o,
    output logic               mem_valid_o,
    output logic               mem_memread_o,
    output logic               mem_memwrite_o,
    output logic [REG_AW-1:0]  mem_rd_o,
    output logic               wb_valid_o,
    output logic               wb_regwrite_o,
    output logic               wb_memtoreg_o,
    output logic [REG_AW-1:0]  wb_rd_o,
    output logic               ex_illegal_o,
    output logic               stall_o,
    output logic               flush_o
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    typedef enum logic {IDLE, STALL} state_t;

    logic       isR, isI, isLoad, isStore, isBr, illegal, usesRs2;
    logic [1:0] aluOp;
    logic       aluSrc, regWrite, hazard, bubble;
    logic       exRegWrite, exMemRead, exMemWrite, exMemToReg;
    logic       memRegWrite, memMemToReg;
    state_t     state;
    logic [1:0] cnt;

    assign isR      = op_i == OP_R;
    assign isI      = op_i == OP_I;
    assign isLoad   = op_i == OP_LOAD;
    assign isStore  = op_i == OP_STORE;
    assign isBr     = (BRANCH_EN != 0) && (op_i == OP_BR);
    assign illegal  = !(isR | isI | isLoad | isStore | isBr);
    assign aluOp    = isStore ? 2'd2 : isBr ? 2'd3 : (isI | isLoad) ? 2'd1 : 2'd0;
    assign aluSrc   = isI | isLoad | isStore;
    assign regWrite = isR | isI | isLoad;
    assign usesRs2  = isR | isStore | isBr;

    assign hazard = ex_valid_o & exMemRead & (ex_rd_o != '0) & valid_i &
                    ((ex_rd_o == rs1_i) | (usesRs2 & (ex_rd_o == rs2_i)));
    assign flush_o = branch_taken_i & ex_valid_o & ex_branch_o;
    assign stall_o = !flush_o & ((state == STALL) | hazard);
    assign bubble  = !valid_i | stall_o | flush_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            cnt            <= '0;
            ex_valid_o     <= 1'b0;
            ex_aluop_o     <= '0;
            ex_alusrc_o    <= 1'b0;
            ex_branch_o    <= 1'b0;
            ex_rd_o        <= '0;
            ex_illegal_o   <= 1'b0;
            exRegWrite     <= 1'b0;
            exMemRead      <= 1'b0;
            exMemWrite     <= 1'b0;
            exMemToReg     <= 1'b0;
            mem_valid_o    <= 1'b0;
            mem_memread_o  <= 1'b0;
            mem_memwrite_o <= 1'b0;
            mem_rd_o       <= '0;
            memRegWrite    <= 1'b0;
            memMemToReg    <= 1'b0;
            wb_valid_o     <= 1'b0;
            wb_regwrite_o  <= 1'b0;
            wb_memtoreg_o  <= 1'b0;
            wb_rd_o        <= '0;
        end else begin
            ex_valid_o     <= !bubble;
            ex_aluop_o     <= bubble ? '0 : ALUOP_W'(aluOp);
            ex_alusrc_o    <= !bubble & aluSrc;
            ex_branch_o    <= !bubble & isBr;
            ex_rd_o        <= (bubble || !regWrite) ? '0 : rd_i;
            ex_illegal_o   <= !bubble & illegal;
            exRegWrite     <= !bubble & regWrite;
            exMemRead      <= !bubble & isLoad;
            exMemWrite     <= !bubble & isStore;
            exMemToReg     <= !bubble & isLoad;
            mem_valid_o    <= ex_valid_o;
            mem_memread_o  <= exMemRead;
            mem_memwrite_o <= exMemWrite;
            mem_rd_o       <= ex_rd_o;
            memRegWrite    <= exRegWrite;
            memMemToReg    <= exMemToReg;
            wb_valid_o     <= mem_valid_o;
            wb_regwrite_o  <= memRegWrite;
            wb_memtoreg_o  <= memMemToReg;
            wb_rd_o        <= mem_rd_o;
            // The first bubble cycle is covered by the live hazard; STALL holds the rest.
            if (flush_o) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (state == IDLE) begin
                if (hazard && STALL_CYCLES > 1) begin
                    state <= STALL;
                    cnt   <= 2'(STALL_CYCLES - 2);
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 2'd1;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: drives a default instance (A) and a STALL_CYCLES=3,
// BRANCH_EN=0, ALUOP_W=4 instance (B) from the same ID-stage inputs.
module tb_control_pipe;
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                           ST = 7'b0100011, BR = 7'b1100011;

    logic clk = 1'b0, rst = 1'b1, valid = 1'b0, bt = 1'b0;
    logic [6:0] op = '0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;

    logic aExValid, aExAlusrc, aExBranch, aExIllegal, aMemValid, aMemMemread, aMemMemwrite;
    logic aWbValid, aWbRegwrite, aWbMemtoreg, aStall, aFlush;
    logic [1:0] aExAluop;
    logic [4:0] aExRd, aMemRd, aWbRd;
    logic bExValid, bExAlusrc, bExBranch, bExIllegal, bMemValid, bMemMemread, bMemMemwrite;
    logic bWbValid, bWbRegwrite, bWbMemtoreg, bStall, bFlush;
    logic [3:0] bExAluop;
    logic [4:0] bExRd, bMemRd, bWbRd;
    logic [30:0] obsA, obsB;

    int nCmp = 0, nBad = 0;

    always #5 clk = ~clk;

    control_pipe dutA (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
        .rd_i(rd), .branch_taken_i(bt), .ex_valid_o(aExValid), .ex_aluop_o(aExAluop),
        .ex_alusrc_o(aExAlusrc), .ex_branch_o(aExBranch), .ex_rd_o(aExRd),
        .mem_valid_o(aMemValid), .mem_memread_o(aMemMemread), .mem_memwrite_o(aMemMemwrite),
        .mem_rd_o(aMemRd), .wb_valid_o(aWbValid), .wb_regwrite_o(aWbRegwrite),
        .wb_memtoreg_o(aWbMemtoreg), .wb_rd_o(aWbRd), .ex_illegal_o(aExIllegal),
        .stall_o(aStall), .flush_o(aFlush)
    );

    control_pipe #(.ALUOP_W(4), .BRANCH_EN(0), .STALL_CYCLES(3)) dutB (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
        .rd_i(rd), .branch_taken_i(bt), .ex_valid_o(bExValid), .ex_aluop_o(bExAluop),
        .ex_alusrc_o(bExAlusrc), .ex_branch_o(bExBranch), .ex_rd_o(bExRd),
        .mem_valid_o(bMemValid), .mem_memread_o(bMemMemread), .mem_memwrite_o(bMemMemwrite),
        .mem_rd_o(bMemRd), .wb_valid_o(bWbValid), .wb_regwrite_o(bWbRegwrite),
        .wb_memtoreg_o(bWbMemtoreg), .wb_rd_o(bWbRd), .ex_illegal_o(bExIllegal),
        .stall_o(bStall), .flush_o(bFlush)
    );

    assign obsA = {aExValid, 2'b00, aExAluop, aExAlusrc, aExBranch, aExRd, aExIllegal,
                   aMemValid, aMemMemread, aMemMemwrite, aMemRd,
                   aWbValid, aWbRegwrite, aWbMemtoreg, aWbRd, aStall, aFlush};
    assign obsB = {bExValid, bExAluop, bExAlusrc, bExBranch, bExRd, bExIllegal,
                   bMemValid, bMemMemread, bMemMemwrite, bMemRd,
                   bWbValid, bWbRegwrite, bWbMemtoreg, bWbRd, bStall, bFlush};

    // Reference model: each stage is a decoded-instruction record; stalls are
    // tracked as a count of remaining bubble cycles.
    typedef struct {
        bit valid; int aluop; bit alusrc, regwrite, memread, memwrite, memtoreg, branch, illegal;
        int rd;
    } ctl_t;

    ctl_t mEx[2], mMem[2], mWb[2];
    int   mLeft[2];
    bit   mHaz[2], mStall[2], mFlush[2];

    function automatic int stallLen(int i);
        return i == 0 ? 1 : 3;
    endfunction

    function automatic ctl_t decode(logic [6:0] o, int r, bit be);
        ctl_t c = '{default: 0};
        c.valid = 1;
        case (o)
            R:  c.regwrite = 1;
            I:  begin c.aluop = 1; c.alusrc = 1; c.regwrite = 1; end
            LD: begin c.aluop = 1; c.alusrc = 1; c.regwrite = 1; c.memread = 1; c.memtoreg = 1; end
            ST: begin c.aluop = 2; c.alusrc = 1; c.memwrite = 1; end
            BR: if (be) begin c.aluop = 3; c.branch = 1; end else c.illegal = 1;
            default: c.illegal = 1;
        endcase
        c.rd = c.regwrite ? r : 0;
        return c;
    endfunction

    function automatic bit readsRs2(logic [6:0] o, bit be);
        return o == R || o == ST || (o == BR && be);
    endfunction

    function automatic logic [30:0] expVec(int i);
        return {mEx[i].valid, 4'(mEx[i].aluop), mEx[i].alusrc, mEx[i].branch, 5'(mEx[i].rd),
                mEx[i].illegal, mMem[i].valid, mMem[i].memread, mMem[i].memwrite, 5'(mMem[i].rd),
                mWb[i].valid, mWb[i].regwrite, mWb[i].memtoreg, 5'(mWb[i].rd), mStall[i], mFlush[i]};
    endfunction

    task automatic evalComb();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            mHaz[i] = mEx[i].valid && mEx[i].memread && mEx[i].rd != 0 && valid &&
                      (mEx[i].rd == int'(rs1) || (readsRs2(op, i == 0) && mEx[i].rd == int'(rs2)));
            mFlush[i] = bt && mEx[i].valid && mEx[i].branch;
            mStall[i] = !mFlush[i] && (mLeft[i] > 0 || mHaz[i]);
        end
    endtask

    task automatic tick();
        ctl_t z = '{default: 0};
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mEx[i] = z; mMem[i] = z; mWb[i] = z; mLeft[i] = 0;
            end else begin
                mWb[i]  = mMem[i];
                mMem[i] = mEx[i];
                mEx[i]  = (!valid || mStall[i] || mFlush[i]) ? z : decode(op, int'(rd), i == 0);
                mLeft[i] = mFlush[i] ? 0 : mLeft[i] > 0 ? mLeft[i] - 1 : mHaz[i] ? stallLen(i) - 1 : 0;
            end
        end
        #1;
    endtask

    task automatic drive(logic v, logic [6:0] o, logic [4:0] a, logic [4:0] b, logic [4:0] d, logic t);
        valid = v; op = o; rs1 = a; rs2 = b; rd = d; bt = t;
    endtask

    task automatic idle(int n);
        drive(0, '0, '0, '0, '0, 0);
        repeat (n) begin evalComb(); tick(); end
    endtask

    task automatic test_reset();
        rst = 1;
        idle(2);
        rst = 0;
        evalComb();
        nCmp += 2;
        if (obsA !== '0) begin nBad++; $display("FAIL reset_A: got %h want 0", obsA); end
        if (obsB !== '0) begin nBad++; $display("FAIL reset_B: got %h want 0", obsB); end
        tick();
    endtask

    task automatic test_rtype();
        drive(1, R, 5'd1, 5'd2, 5'd3, 0);
        evalComb(); tick();
        drive(0, '0, '0, '0, '0, 0);
        evalComb();
        nCmp += 3;
        if (aExAluop !== 2'd0) begin nBad++; $display("FAIL rtype_ex_aluop: got %0d want 0", aExAluop); end
        if (aExRd !== 5'd3) begin nBad++; $display("FAIL rtype_ex_rd: got %0d want 3", aExRd); end
        if (aExValid !== 1'b1) begin nBad++; $display("FAIL rtype_ex_valid: got %b want 1", aExValid); end
        tick();
        evalComb(); tick();
        evalComb();
        nCmp += 4;
        if (aWbRegwrite !== 1'b1) begin nBad++; $display("FAIL rtype_wb_regwrite: got %b want 1", aWbRegwrite); end
        if (aWbRd !== 5'd3) begin nBad++; $display("FAIL rtype_wb_rd: got %0d want 3", aWbRd); end
        if (aWbMemtoreg !== 1'b0) begin nBad++; $display("FAIL rtype_wb_memtoreg: got %b want 0", aWbMemtoreg); end
        if (obsB !== expVec(1)) begin nBad++; $display("FAIL rtype_vec_B: got %h want %h", obsB, expVec(1)); end
        tick();
    endtask

    task automatic test_load_use();
        logic stA[7], stB[7], evA[7], evB[7];
        logic [4:0] rdA[7], rdB[7];
        int nA = 0, nB = 0;
        idle(3);
        drive(1, LD, 5'd0, 5'd0, 5'd5, 0);
        evalComb(); tick();
        for (int k = 0; k < 7; k++) begin
            if (k < 4) drive(1, R, 5'd1, 5'd5, 5'd7, 0);
            else drive(0, '0, '0, '0, '0, 0);
            evalComb();
            nCmp += 2;
            if (obsA !== expVec(0)) begin nBad++; $display("FAIL loaduse_vec_A k=%0d: got %h want %h", k, obsA, expVec(0)); end
            if (obsB !== expVec(1)) begin nBad++; $display("FAIL loaduse_vec_B k=%0d: got %h want %h", k, obsB, expVec(1)); end
            stA[k] = aStall; stB[k] = bStall; evA[k] = aExValid; evB[k] = bExValid;
            rdA[k] = aExRd; rdB[k] = bExRd;
            tick();
        end
        for (int k = 0; k < 7; k++) begin
            nA += int'(stA[k]);
            nB += int'(stB[k]);
        end
        nCmp += 6;
        if (nA != 1) begin nBad++; $display("FAIL loaduse_stall_len_A: got %0d want 1", nA); end
        if (nB != 3 || stB[0] !== 1'b1 || stB[2] !== 1'b1) begin
            nBad++; $display("FAIL loaduse_stall_len_B: got %0d want 3 consecutive", nB);
        end
        if (evA[1] !== 1'b0) begin nBad++; $display("FAIL loaduse_bubble_A: got %b want 0", evA[1]); end
        if (evB[1] !== 1'b0 || evB[2] !== 1'b0 || evB[3] !== 1'b0) begin
            nBad++; $display("FAIL loaduse_bubble_B: got %b%b%b want 000", evB[1], evB[2], evB[3]);
        end
        if (evA[2] !== 1'b1 || rdA[2] !== 5'd7) begin
            nBad++; $display("FAIL loaduse_resume_A: got valid=%b rd=%0d want 1/7", evA[2], rdA[2]);
        end
        if (evB[4] !== 1'b1 || rdB[4] !== 5'd7) begin
            nBad++; $display("FAIL loaduse_resume_B: got valid=%b rd=%0d want 1/7", evB[4], rdB[4]);
        end
    endtask

    task automatic test_x0();
        idle(3);
        drive(1, LD, 5'd1, 5'd0, 5'd0, 0);
        evalComb(); tick();
        drive(1, R, 5'd0, 5'd0, 5'd4, 0);
        evalComb();
        nCmp += 2;
        if (aStall !== 1'b0) begin nBad++; $display("FAIL x0_stall_A: got %b want 0", aStall); end
        if (bStall !== 1'b0) begin nBad++; $display("FAIL x0_stall_B: got %b want 0", bStall); end
        tick();
    endtask

    task automatic test_flush();
        idle(3);
        drive(1, BR, 5'd1, 5'd2, 5'd0, 0);
        evalComb(); tick();
        drive(1, R, 5'd1, 5'd2, 5'd6, 1);
        evalComb();
        nCmp += 3;
        if (aFlush !== 1'b1) begin nBad++; $display("FAIL flush_A: got %b want 1", aFlush); end
        if (aStall !== 1'b0) begin nBad++; $display("FAIL flush_stall_A: got %b want 0", aStall); end
        if (bFlush !== 1'b0) begin nBad++; $display("FAIL flush_disabled_B: got %b want 0", bFlush); end
        tick();
        drive(0, '0, '0, '0, '0, 0);
        evalComb();
        nCmp += 3;
        if (aExValid !== 1'b0) begin nBad++; $display("FAIL flush_bubble_A: got %b want 0", aExValid); end
        if (aMemValid !== 1'b1) begin nBad++; $display("FAIL flush_branch_mem_A: got %b want 1", aMemValid); end
        if (bExValid !== 1'b1) begin nBad++; $display("FAIL flush_noflush_B: got %b want 1", bExValid); end
        tick();
    endtask

    task automatic test_illegal();
        idle(3);
        drive(1, 7'b1111111, 5'd1, 5'd2, 5'd9, 0);
        evalComb(); tick();
        drive(1, BR, 5'd1, 5'd2, 5'd9, 0);
        evalComb();
        nCmp += 2;
        if ({aExIllegal, aExAluop, aExAlusrc, aExBranch, aExRd} !== {1'b1, 2'd0, 1'b0, 1'b0, 5'd0}) begin
            nBad++; $display("FAIL illegal_ex_A: got ill=%b aop=%0d src=%b br=%b rd=%0d want 1/0/0/0/0",
                             aExIllegal, aExAluop, aExAlusrc, aExBranch, aExRd);
        end
        if ({bExIllegal, bExAluop, bExAlusrc, bExBranch, bExRd} !== {1'b1, 4'd0, 1'b0, 1'b0, 5'd0}) begin
            nBad++; $display("FAIL illegal_ex_B: got ill=%b aop=%0d src=%b br=%b rd=%0d want 1/0/0/0/0",
                             bExIllegal, bExAluop, bExAlusrc, bExBranch, bExRd);
        end
        tick();
        drive(0, '0, '0, '0, '0, 0);
        evalComb();
        nCmp += 2;
        if ({bExIllegal, bExBranch, bExAluop} !== {1'b1, 1'b0, 4'd0}) begin
            nBad++; $display("FAIL illegal_branch_B: got ill=%b br=%b aop=%0d want 1/0/0", bExIllegal, bExBranch, bExAluop);
        end
        if ({aExIllegal, aExBranch, aExAluop} !== {1'b0, 1'b1, 2'd3}) begin
            nBad++; $display("FAIL legal_branch_A: got ill=%b br=%b aop=%0d want 0/1/3", aExIllegal, aExBranch, aExAluop);
        end
        tick();
        evalComb();
        nCmp += 2;
        if ({aWbValid, aWbRegwrite} !== 2'b10) begin
            nBad++; $display("FAIL illegal_wb_A: got valid=%b regwrite=%b want 1/0", aWbValid, aWbRegwrite);
        end
        if (bWbRegwrite !== 1'b0) begin nBad++; $display("FAIL illegal_wb_B: got %b want 0", bWbRegwrite); end
        tick();
    endtask

    task automatic test_store_aluop();
        idle(2);
        drive(1, ST, 5'd1, 5'd2, 5'd9, 0);
        evalComb(); tick();
        drive(0, '0, '0, '0, '0, 0);
        evalComb();
        nCmp += 3;
        if (bExAluop !== 4'b0010) begin nBad++; $display("FAIL store_aluop_B: got %b want 0010", bExAluop); end
        if (aExAluop !== 2'b10) begin nBad++; $display("FAIL store_aluop_A: got %b want 10", aExAluop); end
        if (bExRd !== 5'd0 || bExAlusrc !== 1'b1) begin
            nBad++; $display("FAIL store_rd_src_B: got rd=%0d src=%b want 0/1", bExRd, bExAlusrc);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        idle(3);
        drive(1, LD, 5'd0, 5'd0, 5'd5, 0);
        evalComb(); tick();
        drive(1, R, 5'd5, 5'd0, 5'd7, 0);
        evalComb(); tick();
        rst = 1;
        evalComb();
        nCmp++;
        if (bStall !== 1'b1) begin nBad++; $display("FAIL midstall_before_B: got %b want 1", bStall); end
        tick();
        rst = 0;
        drive(0, '0, '0, '0, '0, 0);
        evalComb();
        nCmp += 2;
        if (obsB !== '0) begin nBad++; $display("FAIL midstall_reset_B: got %h want 0", obsB); end
        if (obsA !== '0) begin nBad++; $display("FAIL midstall_reset_A: got %h want 0", obsA); end
        tick();
        evalComb();
        nCmp++;
        if (bStall !== 1'b0) begin nBad++; $display("FAIL midstall_idle_B: got %b want 0", bStall); end
        tick();
    endtask

    task automatic test_random();
        logic [6:0] opTab[5] = '{R, I, LD, ST, BR};
        for (int n = 0; n < 500; n++) begin
            int sel = $urandom_range(0, 5);
            rst = $urandom_range(0, 99) == 0;
            drive($urandom_range(0, 9) < 8, sel < 5 ? opTab[sel] : 7'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
            evalComb();
            nCmp += 2;
            if (obsA !== expVec(0)) begin nBad++; $display("FAIL random_vec_A n=%0d: got %h want %h", n, obsA, expVec(0)); end
            if (obsB !== expVec(1)) begin nBad++; $display("FAIL random_vec_B n=%0d: got %h want %h", n, obsB, expVec(1)); end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        #1;
        test_reset();
        test_rtype();
        test_load_use();
        test_x0();
        test_flush();
        test_illegal();
        test_store_aluop();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
